// File: rtl/mux_nx1_reg_if.sv
// Channel-side and consumer-side signals of the registered N:1 mux.
// The mux itself takes the slave view; the producer/consumer side takes master.
interface mux_nx1_reg_if #(
  parameter int DATA_WIDTH = 11,
  parameter int NUM_INPUTS = 4,
  parameter int SEL_WIDTH  = 2
);
  logic [NUM_INPUTS*DATA_WIDTH-1:0] in_data;
  logic [NUM_INPUTS-1:0]            in_valid;
  logic [NUM_INPUTS-1:0]            in_ready;
  logic                             mode;
  logic [SEL_WIDTH-1:0]             select_nx1;
  logic [DATA_WIDTH-1:0]            mux_out;
  logic                             out_valid;
  logic                             out_ready;
  logic [SEL_WIDTH-1:0]             grant_sel;
  logic                             sel_error;

  modport master (
    output in_data, in_valid, mode,
    output select_nx1, out_ready,
    input  in_ready, mux_out, out_valid,
    input  grant_sel, sel_error
  );

  modport slave (
    input  in_data, in_valid, mode,
    input  select_nx1, out_ready,
    output in_ready, mux_out, out_valid,
    output grant_sel, sel_error
  );
endinterface

// File: rtl/mux_nx1_reg.sv
// N:1 mux with fixed or round-robin arbitration into a
// one-entry output register with valid/ready flow control.
module mux_nx1_reg #(
  parameter int DATA_WIDTH = 11,
  parameter int NUM_INPUTS = 4,
  parameter int SEL_WIDTH  = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  mux_nx1_reg_if.slave bus
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  state_e                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic [SEL_WIDTH-1:0]    gsel_q, gsel_d;
  logic [SEL_WIDTH-1:0]    ptr_q, ptr_d;
  logic                    err_q, err_d;

  logic [SEL_WIDTH-1:0]    g;
  logic [SEL_WIDTH-1:0]    idx;
  logic                    g_ok;
  logic                    can_load;
  logic                    xfer;
  logic [NUM_INPUTS-1:0]   ready;

  // Descending scan so the nearest valid channel after ptr_q wins.
  always_comb begin
    g    = '0;
    g_ok = 1'b0;
    idx  = '0;
    unique case (1'b1)
      !bus.mode: begin
        g_ok = int'(bus.select_nx1) < NUM_INPUTS;
        if (g_ok) g = bus.select_nx1;
      end
      bus.mode: begin
        for (int k = NUM_INPUTS; k >= 1; k--) begin
          idx = SEL_WIDTH'((int'(ptr_q) + k) % NUM_INPUTS);
          if (bus.in_valid[idx]) begin
            g    = idx;
            g_ok = 1'b1;
          end
        end
      end
    endcase
  end

  always_comb begin
    can_load = (state_q == EMPTY) || bus.out_ready;
    ready    = '0;
    if (g_ok && can_load && rst_n) ready[g] = 1'b1;
    xfer     = |(ready & bus.in_valid);
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      EMPTY: if (xfer) state_d = FULL;
      FULL:  if (bus.out_ready && !xfer) state_d = EMPTY;
    endcase
  end

  always_comb begin
    data_d = data_q;
    gsel_d = gsel_q;
    ptr_d  = ptr_q;
    err_d  = err_q |
             (!bus.mode &&
              int'(bus.select_nx1) >= NUM_INPUTS);
    if (xfer) begin
      data_d = bus.in_data[int'(g)*DATA_WIDTH +: DATA_WIDTH];
      gsel_d = g;
      ptr_d  = g;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      data_q  <= '0;
      gsel_q  <= '0;
      ptr_q   <= SEL_WIDTH'(NUM_INPUTS - 1);
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      gsel_q  <= gsel_d;
      ptr_q   <= ptr_d;
      err_q   <= err_d;
    end
  end

  assign bus.in_ready  = ready;
  assign bus.out_valid = (state_q == FULL);
  assign bus.mux_out   = data_q;
  assign bus.grant_sel = gsel_q;
  assign bus.sel_error = err_q;

endmodule

// File: tb/tb_mux_nx1_reg.sv
// Directed bench for mux_nx1_reg: a spec-level model checked every
// cycle, plus literal expectations for the documented scenarios.
module tb_mux_nx1_reg;
  localparam int DW = 11;
  localparam int N  = 4;
  localparam int SW = 2;

  logic clk = 1'b0;
  logic rst_n;
  logic chk_en = 1'b0;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  mux_nx1_reg_if #(.DATA_WIDTH(DW), .NUM_INPUTS(N), .SEL_WIDTH(SW)) bus ();
  mux_nx1_reg_if #(.DATA_WIDTH(DW), .NUM_INPUTS(3), .SEL_WIDTH(2)) bus3 ();

  mux_nx1_reg #(.DATA_WIDTH(DW), .NUM_INPUTS(N), .SEL_WIDTH(SW)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  mux_nx1_reg #(.DATA_WIDTH(DW), .NUM_INPUTS(3), .SEL_WIDTH(2)) dut3 (
    .clk(clk), .rst_n(rst_n), .bus(bus3)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: output register contents and the last transferred channel.
  logic          m_full;
  logic [DW-1:0] m_data;
  logic [SW-1:0] m_gsel;
  int            m_ptr;
  logic          m_err;

  function automatic logic [N-1:0] m_ready();
    logic [N-1:0] r = '0;
    int s;
    if (!rst_n) return '0;
    if (m_full && !bus.out_ready) return '0;
    if (!bus.mode) begin
      if (int'(bus.select_nx1) < N) r[bus.select_nx1] = 1'b1;
    end else begin
      for (int k = 1; k <= N; k++) begin
        s = (m_ptr + k) % N;
        if (bus.in_valid[s]) begin
          r[s] = 1'b1;
          break;
        end
      end
    end
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    logic [N-1:0] t;
    if (!rst_n) begin
      m_full <= 1'b0;
      m_data <= '0;
      m_gsel <= '0;
      m_ptr  <= N - 1;
      m_err  <= 1'b0;
    end else begin
      t = m_ready() & bus.in_valid;
      if (t != '0) begin
        for (int i = 0; i < N; i++) begin
          if (t[i]) begin
            m_full <= 1'b1;
            m_data <= bus.in_data[i*DW +: DW];
            m_gsel <= SW'(i);
            m_ptr  <= i;
          end
        end
      end else if (m_full && bus.out_ready) begin
        m_full <= 1'b0;
      end
      if (!bus.mode && int'(bus.select_nx1) >= N) m_err <= 1'b1;
    end
  end

  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      chk("m_in_ready", 32'(bus.in_ready), 32'(m_ready()));
      chk("m_out_valid", 32'(bus.out_valid), 32'(m_full));
      chk("m_mux_out", 32'(bus.mux_out), 32'(m_data));
      chk("m_grant_sel", 32'(bus.grant_sel), 32'(m_gsel));
      chk("m_sel_error", 32'(bus.sel_error), 32'(m_err));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int i, input logic [DW-1:0] v);
    bus.in_data[i*DW +: DW] = v;
  endtask

  typedef struct {
    logic          mode;
    logic [SW-1:0] sel;
    logic [N-1:0]  valid;
    logic          ordy;
  } vec_t;

  vec_t vecs[10] = '{
    '{1'b1, 2'd0, 4'b0110, 1'b1},
    '{1'b1, 2'd0, 4'b0110, 1'b0},
    '{1'b1, 2'd0, 4'b0000, 1'b1},
    '{1'b1, 2'd0, 4'b0000, 1'b1},
    '{1'b0, 2'd3, 4'b0111, 1'b1},
    '{1'b0, 2'd3, 4'b1000, 1'b0},
    '{1'b0, 2'd3, 4'b1000, 1'b1},
    '{1'b1, 2'd3, 4'b1001, 1'b1},
    '{1'b1, 2'd3, 4'b1001, 1'b1},
    '{1'b1, 2'd3, 4'b1001, 1'b1}
  };

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bus.in_data     = '0;
    bus.in_valid    = '0;
    bus.mode        = 1'b0;
    bus.select_nx1  = '0;
    bus.out_ready   = 1'b1;
    bus3.in_data    = '0;
    bus3.in_valid   = '0;
    bus3.mode       = 1'b0;
    bus3.select_nx1 = '0;
    bus3.out_ready  = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_mux_out", 32'(bus.mux_out), 32'd0);
    chk("rst_grant_sel", 32'(bus.grant_sel), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_sel_error", 32'(bus.sel_error), 32'd0);
    rst_n  = 1'b1;
    chk_en = 1'b1;

    // Fixed select of channel 1.
    set_ch(1, 11'b11101001001);
    bus.select_nx1 = 2'd1;
    bus.in_valid   = 4'b0010;
    #1;
    chk("fix_in_ready", 32'(bus.in_ready), 32'b0010);
    step();
    chk("fix_mux_out", 32'(bus.mux_out), 32'(11'b11101001001));
    chk("fix_out_valid", 32'(bus.out_valid), 32'd1);
    chk("fix_grant_sel", 32'(bus.grant_sel), 32'd1);
    bus.in_valid = 4'b0000;
    step();
    chk("drain_out_valid", 32'(bus.out_valid), 32'd0);
    chk("drain_mux_hold", 32'(bus.mux_out), 32'(11'b11101001001));

    // Round-robin from reset starts at channel 0.
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < N; i++) set_ch(i, DW'(16 * i + 3));
    bus.mode     = 1'b1;
    bus.in_valid = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("rr_seq_grant", 32'(bus.grant_sel), 32'(i % N));
    end

    // Pointer now 0; channels 0 and 2 alternate.
    bus.in_valid = 4'b0101;
    step();
    chk("rr_wrap_g2", 32'(bus.grant_sel), 32'd2);
    step();
    chk("rr_wrap_g0", 32'(bus.grant_sel), 32'd0);
    step();
    chk("rr_wrap_g2b", 32'(bus.grant_sel), 32'd2);

    // Backpressure holds the word and blocks every channel.
    set_ch(0, 11'b00001100100);
    set_ch(2, 11'h5a5);
    bus.mode       = 1'b0;
    bus.select_nx1 = 2'd0;
    step();
    chk("bp_load", 32'(bus.mux_out), 32'(11'b00001100100));
    bus.out_ready = 1'b0;
    bus.mode      = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
      step();
      chk("bp_mux_hold", 32'(bus.mux_out), 32'(11'b00001100100));
      chk("bp_valid_hold", 32'(bus.out_valid), 32'd1);
    end
    bus.out_ready = 1'b1;
    #1;
    chk("bp_release_rdy", 32'(bus.in_ready), 32'b0100);
    step();
    chk("bp_release_data", 32'(bus.mux_out), 32'(11'h5a5));
    chk("bp_release_gsel", 32'(bus.grant_sel), 32'd2);

    // Out-of-range fixed select on the 3-input instance.
    bus3.select_nx1 = 2'd3;
    bus3.in_valid   = 3'b111;
    for (int i = 0; i < 3; i++) bus3.in_data[i*DW +: DW] = DW'(i + 7);
    #1;
    chk("oor_in_ready", 32'(bus3.in_ready), 32'd0);
    chk("oor_err_pre", 32'(bus3.sel_error), 32'd0);
    step();
    chk("oor_out_valid", 32'(bus3.out_valid), 32'd0);
    chk("oor_err_set", 32'(bus3.sel_error), 32'd1);
    bus3.select_nx1 = 2'd0;
    step();
    chk("oor_err_sticky", 32'(bus3.sel_error), 32'd1);
    chk("oor_then_valid", 32'(bus3.out_valid), 32'd1);

    // Asynchronous reset while FULL, then channel 3 alone.
    set_ch(3, 11'h6c1);
    bus.out_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("arst_mux_out", 32'(bus.mux_out), 32'd0);
    chk("arst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("arst_err_clr", 32'(bus3.sel_error), 32'd0);
    bus.mode      = 1'b1;
    bus.in_valid  = 4'b1000;
    bus.out_ready = 1'b1;
    rst_n = 1'b1;
    #1;
    chk("arst_rdy_ch3", 32'(bus.in_ready), 32'b1000);
    step();
    chk("arst_grant3", 32'(bus.grant_sel), 32'd3);
    chk("arst_data3", 32'(bus.mux_out), 32'(11'h6c1));

    // Mixed traffic under the model.
    for (int i = 0; i < 4; i++) set_ch(i, DW'(100 * i + 9));
    foreach (vecs[i]) begin
      bus.mode       = vecs[i].mode;
      bus.select_nx1 = vecs[i].sel;
      bus.in_valid   = vecs[i].valid;
      bus.out_ready  = vecs[i].ordy;
      step();
    end
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
